cbus_arbiter_rr: RTL

- N-input arbiter onto the single cached-bus master port. Successor to the current fixed-priority arbiter.
- Adds selectable fixed or round-robin priority and a generic address-translation handshake in place of a hard-wired translator.
- Adds fault return to the requester and an abort path for requests withdrawn before issue.
- Sits between the I/D cache request ports and the memory-side cbus; the page-table walker attaches to the tr_* ports.

---
 rtl/cbus_arbiter_rr_pkg.sv | 37 +++
 rtl/cbus_arbiter_rr_picker.sv | 44 ++++
 rtl/cbus_arbiter_rr.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_rr_pkg.sv
// Shared types and constants for the cached-bus arbiter and its picker.
// Provides the address/request/response payloads, the arbiter state encoding
// and the priority-mode selector values.
package cbus_arbiter_rr_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  // Priority mode selector values for ARB_MODE / MODE parameters
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    XLATE,
    ISSUE,
    FAULT
  } arb_state_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [LEN_W-1:0]  len;
    addr_t             addr;
    logic [DATA_W-1:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational requester picker (the rr_picker block).
// Ports: valid  - one request bit per requester
//        rr_ptr - round-robin start index (ignored in fixed mode)
//        any    - at least one requester is valid
//        idx    - chosen requester
// MODE = ARB_FIXED picks the lowest valid index; MODE = ARB_RR picks the first
// valid index at or above rr_ptr, wrapping modulo NUM_INPUTS.
module cbus_arbiter_rr_picker
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned MODE       = ARB_RR,
  localparam int unsigned IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic                  any,
  output logic [IDX_W-1:0]      idx
);

  int unsigned cand;

  // Scan from the start index; first hit wins
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (MODE == ARB_RR) begin
        cand = 32'(rr_ptr) + 32'(k);
        if (cand >= NUM_INPUTS) begin
          cand = cand - NUM_INPUTS;
        end
      end else begin
        cand = 32'(k);
      end
      if (!any && valid[cand]) begin
        any = 1'b1;
        idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// N-input arbiter onto the cached-bus master port with fixed or round-robin
// priority, optional address translation handshake, fault return and abort of
// requests withdrawn during translation.
// Ports: clk, reset (sync, active-high)
//        ireqs/iresps   - requester side (one slot per input)
//        oreq/oresp     - memory-side cbus
//        xlat_en        - translation enabled, sampled in IDLE only
//        tr_req/tr_vaddr/tr_done/tr_paddr/tr_fault - walker handshake
//        fault          - one-cycle fault pulse per requester
//        grant_idx      - current owner, valid when not IDLE
// Optional: define CBUS_ARB_STATS_EN to add grant_cnt / fault_cnt counters.
module cbus_arbiter_rr
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned ARB_MODE   = ARB_RR,
  localparam int unsigned IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  input  logic                         xlat_en,
  output logic                         tr_req,
  output addr_t                        tr_vaddr,
  input  logic                         tr_done,
  input  addr_t                        tr_paddr,
  input  logic                         tr_fault,
  output logic [NUM_INPUTS-1:0]        fault,
  output logic [IDX_W-1:0]             grant_idx
`ifdef CBUS_ARB_STATS_EN
  ,
  output logic [NUM_INPUTS-1:0][31:0]  grant_cnt,
  output logic [31:0]                  fault_cnt
`endif
);

  arb_state_t              state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        rr_ptr;
  addr_t                   paddr_q;

  logic [NUM_INPUTS-1:0]   valid_vec;
  logic                    pick_any;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        idx_inc;
  logic [IDX_W-1:0]        rr_next;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  cbus_arbiter_rr_picker #(
    .NUM_INPUTS (NUM_INPUTS),
    .MODE       (ARB_MODE)
  ) u_picker (
    .valid  (valid_vec),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Pointer moves past the finishing owner only in round-robin mode
  always_comb begin
    idx_inc = (idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : idx + IDX_W'(1);
    rr_next = (ARB_MODE == ARB_RR) ? idx_inc : rr_ptr;
  end

  // Arbitration FSM with registered tr_req / fault
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      rr_ptr  <= '0;
      paddr_q <= '0;
      tr_req  <= 1'b0;
      fault   <= '0;
    end else begin
      fault <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            idx <= pick_idx;
            if (xlat_en) begin
              state  <= XLATE;
              tr_req <= 1'b1;
            end else begin
              state   <= ISSUE;
              paddr_q <= ireqs[pick_idx].addr;
            end
          end
        end
        XLATE: begin
          // Withdrawal wins over a same-cycle completion; late tr_done is dropped in IDLE
          if (!ireqs[idx].valid) begin
            state  <= IDLE;
            tr_req <= 1'b0;
          end else if (tr_done) begin
            tr_req <= 1'b0;
            if (tr_fault) begin
              state      <= FAULT;
              fault[idx] <= 1'b1;
            end else begin
              state   <= ISSUE;
              paddr_q <= tr_paddr;
            end
          end
        end
        ISSUE: begin
          if (oresp.ready && oresp.last) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end
        end
        FAULT: begin
          state  <= IDLE;
          rr_ptr <= rr_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus steering decoded from the registered state
  always_comb begin
    oreq     = '0;
    iresps   = '0;
    tr_vaddr = '0;
    case (state)
      XLATE: tr_vaddr = ireqs[idx].addr;
      ISSUE: begin
        oreq        = ireqs[idx];
        oreq.addr   = paddr_q;
        oreq.valid  = 1'b1;
        iresps[idx] = oresp;
      end
      FAULT: begin
        iresps[idx].ready = 1'b1;
        iresps[idx].last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_idx = idx;

`ifdef CBUS_ARB_STATS_EN
  // Saturating per-owner completion and fault counters
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
      fault_cnt <= '0;
    end else begin
      if (state == ISSUE && oresp.ready && oresp.last && grant_cnt[idx] != '1) begin
        grant_cnt[idx] <= grant_cnt[idx] + 32'd1;
      end
      if (state == FAULT && fault_cnt != '1) begin
        fault_cnt <= fault_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
